// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter between per-CPU fetch ports and one shared instruction memory.
// Grant and memory address are combinational; response data/valid and last-grant are registered.
module instr_mem_arbiter #(
    parameter int nCPUs     = 3,
    parameter int addrWidth = 32,
    parameter int dataWidth = 32,
    localparam int IdxW     = $clog2((nCPUs > 2) ? nCPUs : 2)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [nCPUs-1:0]                     req,
    input  logic [nCPUs-1:0][addrWidth-1:0]      reqAddr,
    output logic [nCPUs-1:0]                     gnt,
    output logic [addrWidth-1:0]                 imAddr,
    input  logic [dataWidth-1:0]                 imData,
    output logic [nCPUs-1:0]                     rspValid,
    output logic [nCPUs-1:0][dataWidth-1:0]      rspData,
    output logic [IdxW-1:0]                      lastGnt
);

    logic [nCPUs-1:0]                rspValid_q, rspValid_d;
    logic [nCPUs-1:0][dataWidth-1:0] rspData_q, rspData_d;
    logic [IdxW-1:0]                 lastGnt_q, lastGnt_d;

    logic [IdxW-1:0] win_s;
    logic            found_s;
    logic [IdxW:0]   cand_s;

    // Search starts one past the last winner; the sum never exceeds 2*nCPUs-1, so one subtract wraps it
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int off = 1; off <= nCPUs; off++) begin
            cand_s = {1'b0, lastGnt_q} + (IdxW+1)'(off);
            if (cand_s >= (IdxW+1)'(nCPUs)) begin
                cand_s = cand_s - (IdxW+1)'(nCPUs);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IdxW-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s[IdxW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (rst) begin
            found_s = 1'b0;
        end else begin
            found_s = found_s;
        end
    end

    // Drive the grant vector and the shared memory address
    always_comb begin
        gnt    = '0;
        imAddr = '0;
        if (found_s) begin
            gnt[win_s] = 1'b1;
            imAddr     = reqAddr[win_s];
        end else begin
            gnt    = '0;
            imAddr = '0;
        end
    end

    // Capture the read data for the winner; everything else holds
    always_comb begin
        rspValid_d = '0;
        rspData_d  = rspData_q;
        lastGnt_d  = lastGnt_q;
        if (found_s) begin
            rspValid_d[win_s] = 1'b1;
            rspData_d[win_s]  = imData;
            lastGnt_d         = win_s;
        end else begin
            rspValid_d = '0;
        end
    end

    // State registers; after reset the last grant points at the top CPU so CPU 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            rspValid_q <= '0;
            rspData_q  <= '0;
            lastGnt_q  <= IdxW'(nCPUs - 1);
        end else begin
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            lastGnt_q  <= lastGnt_d;
        end
    end

    assign rspValid = rspValid_q;
    assign rspData  = rspData_q;
    assign lastGnt  = lastGnt_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed and randomised self-checking bench for instr_mem_arbiter with three CPUs.
module tb_instr_mem_arbiter;

    logic             clk;
    logic             rst;
    logic [2:0]       req;
    logic [2:0][31:0] req_addr;
    logic [2:0]       gnt;
    logic [31:0]      im_addr;
    logic [31:0]      im_data;
    logic [2:0]       rsp_valid;
    logic [2:0][31:0] rsp_data;
    logic [1:0]       last_gnt;

    int          n_checks;
    int          n_fail;
    int          exp_last;
    logic [31:0] exp_data [3];
    logic [2:0]  pend;
    int          wait_c [3];

    instr_mem_arbiter #(.nCPUs(3), .addrWidth(32), .dataWidth(32)) dut (
        .clk(clk), .rst(rst), .req(req), .reqAddr(req_addr), .gnt(gnt),
        .imAddr(im_addr), .imData(im_data), .rspValid(rsp_valid),
        .rspData(rsp_data), .lastGnt(last_gnt)
    );

    assign im_data = im_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs are already driven; w is the expected winner or -1 for no grant
    task automatic expect_grant(input int w);
        #4;
        check_eq("gnt", 64'(gnt), (w >= 0) ? 64'(3'b001 << w) : 64'd0);
        check_eq("im_addr", 64'(im_addr), (w >= 0) ? 64'(req_addr[w]) : 64'd0);
        if (w >= 0) begin
            exp_data[w] = req_addr[w] ^ 32'hA5A5_0000;
            exp_last    = w;
        end
        @(posedge clk); #1;
        check_eq("rsp_valid", 64'(rsp_valid), (w >= 0) ? 64'(3'b001 << w) : 64'd0);
        check_eq("last_gnt", 64'(last_gnt), 64'(exp_last));
        for (int i = 0; i < 3; i++) check_eq("rsp_data", 64'(rsp_data[i]), 64'(exp_data[i]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b111;
        #4;
        check_eq("rst_gnt", 64'(gnt), 64'd0);
        check_eq("rst_im_addr", 64'(im_addr), 64'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_last = 2;
        for (int i = 0; i < 3; i++) exp_data[i] = 32'h0;
        check_eq("rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_last", 64'(last_gnt), 64'd2);
        for (int i = 0; i < 3; i++) check_eq("rst_data", 64'(rsp_data[i]), 64'd0);
    endtask

    initial begin
        int w;
        int ew;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 3'b000;
        pend     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = 32'h100 * i;
            exp_data[i] = 32'h0;
            wait_c[i]   = 0;
        end
        @(posedge clk); #1;

        // All three requesting: 0,1,2,0,1,2
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 6; k++) expect_grant(k % 3);
        check_eq("rr_data1", 64'(rsp_data[1]), 64'h0000_0000_A5A5_0100);

        // Sole requester re-granted every cycle
        req = 3'b100;
        for (int k = 0; k < 4; k++) expect_grant(2);
        check_eq("sole_last", 64'(last_gnt), 64'd2);

        // Two requesters alternate, CPU 1 untouched
        do_reset();
        req = 3'b101;
        expect_grant(0);
        expect_grant(2);
        expect_grant(0);
        expect_grant(2);
        check_eq("skip_data1", 64'(rsp_data[1]), 64'd0);

        // Single grant then idle: data held, valid drops
        req_addr[1] = 32'h30;
        req = 3'b010;
        expect_grant(1);
        req = 3'b000;
        for (int k = 0; k < 5; k++) begin
            expect_grant(-1);
            check_eq("hold_data1", 64'(rsp_data[1]), 64'h0000_0000_A5A5_0030);
        end
        req_addr[1] = 32'h100;

        // Mid-stream reset with last grant at 1
        check_eq("pre_rst_last", 64'(last_gnt), 64'd1);
        do_reset();
        req = 3'b111;
        expect_grant(0);

        // Random requesters that hold until granted, with a reference round-robin model
        req = 3'b000;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i]) begin
                    pend[i]   = 1'($urandom & 1);
                    wait_c[i] = 0;
                end
                if ($urandom_range(0, 3) == 0) req_addr[i] = $urandom;
            end
            req = pend;
            ew  = -1;
            for (int off = 1; off <= 3; off++) begin
                if (ew < 0 && req[(exp_last + off) % 3]) ew = (exp_last + off) % 3;
            end
            #4;
            check_eq("rnd_onehot", 64'($onehot0(gnt)), 64'd1);
            check_eq("rnd_gnt", 64'(gnt), (ew >= 0) ? 64'(3'b001 << ew) : 64'd0);
            w = -1;
            for (int i = 0; i < 3; i++) if (gnt[i]) w = i;
            check_eq("rnd_im_addr", 64'(im_addr), (ew >= 0) ? 64'(req_addr[ew]) : 64'd0);
            if (ew >= 0) begin
                exp_data[ew] = req_addr[ew] ^ 32'hA5A5_0000;
                exp_last     = ew;
            end
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && !gnt[i]) begin
                    wait_c[i]++;
                    check_eq("rnd_wait", 64'(wait_c[i] <= 2), 64'd1);
                end
            end
            @(posedge clk); #1;
            check_eq("rnd_valid", 64'(rsp_valid), (ew >= 0) ? 64'(3'b001 << ew) : 64'd0);
            for (int i = 0; i < 3; i++) check_eq("rnd_data", 64'(rsp_data[i]), 64'(exp_data[i]));
            if (w >= 0) pend[w] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Round-robin arbiter between the per-CPU fetch ports of `cpu_cluster` and the single shared instruction memory. Each cycle it picks at most one requesting CPU and drives its fetch address to the memory. It captures the combinational read data into that CPU's private instruction register and pulses a per-CPU valid. It sits directly upstream of the instruction memory and feeds every CPU's fetch stage. CPUs without a grant stall.

## Interface
- `nCPUs`, default 3: number of CPU fetch ports; legal range 1..8.
- `addrWidth`, default 32: fetch address width (byte address).
- `dataWidth`, default 32: instruction width.
- `clk`  in  1: clock. All state updates on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  nCPUs: CPU i requests a fetch this cycle.
- `reqAddr`  in  [nCPUs-1:0][addrWidth-1:0]: fetch address of CPU i.
- `gnt`  out  nCPUs: one-hot or zero (combinational). CPU i's request is accepted this cycle.
- `imAddr`  out  addrWidth: address to shared memory (combinational). Equals `reqAddr[winner]`, or 0 when no grant.
- `imData`  in  dataWidth: shared memory read data. Combinational function of `imAddr`.
- `rspValid`  out  nCPUs: registered. Bit i is high for exactly one cycle after CPU i was granted.
- `rspData`  out  [nCPUs-1:0][dataWidth-1:0]: registered per-CPU instruction. Holds its value until the next grant to that CPU.
- `lastGnt`  out  $clog2(max(nCPUs,2)): registered index of the most recently granted CPU. Used for debug and bench.

## Operation
- Round-robin search starts at `lastGnt+1`, wraps modulo nCPUs, and picks the first i with `req[i]`=1.
  - `gnt[i]`=1 only for the winner.
  - All-zero when `req`=0 or `rst`=1.
- On a grant:
  - `rspData[winner] <= imData`
  - `rspValid <= onehot(winner)`
  - `lastGnt <= winner`
- No grant: `rspValid <= 0`; `lastGnt` and all `rspData` unchanged.
- Fairness: with k CPUs requesting continuously, each is granted exactly once every k cycles. Worst-case wait is nCPUs-1 cycles.
- Requester protocol:
  - A CPU holds `req` and `reqAddr` stable until it sees `gnt`.
  - It may drop `req` before grant with no side effect; the arbiter keeps no per-request state.
  - `reqAddr` changes while ungranted are legal. The granted cycle's value is the one used.
- nCPUs=1: `gnt[0]`=`req[0]`, `lastGnt` stays 0.
- `imAddr` is passed through unmodified; word selection is the memory's job.

## Timing
- Reset values:
  - `rspValid`=0
  - `rspData[i]`=0 for all i
  - `lastGnt`=nCPUs-1, so CPU 0 has first priority after reset
  - `gnt`=0 and `imAddr`=0 while `rst`=1
- Latency: `req` and grant in cycle N. `rspData[i]` and `rspValid[i]` are visible in cycle N+1, one cycle after grant.
- Back-to-back: a CPU re-granted in N+1 (e.g. it is the sole requester) gets `rspValid` in N+1 and N+2, with a new `rspData` each cycle. Throughput is 1 fetch/cycle aggregate.
- Reset mid-operation: `rst` sampled high at edge E clears all registers at E and overrides any grant computed in that cycle. The first grant after reset falls in the first cycle with `rst`=0 and goes to the lowest-index requester.
- Simultaneous requests from all CPUs in the same cycle as `lastGnt` wraps (`lastGnt`=nCPUs-1): winner is CPU 0.
- `req` rising in the same cycle another CPU is granted: that CPU waits; it is considered from the next cycle.

## Test plan
Bench memory model: `imData = imAddr ^ 32'hA5A5_0000`. `reqAddr[i] = 32'h100*i`.

- Reset, then `req`=3'b111 constant for 6 cycles.
  - Grants go 0,1,2,0,1,2.
  - `rspValid` follows one cycle later.
  - `rspData[1]`=32'hA5A5_0100.
- Only `req[2]`=1 for 4 cycles.
  - `gnt`=3'b100 every cycle.
  - `rspValid[2]` high 4 consecutive cycles.
  - `lastGnt`=2.
- `req`=3'b101 after reset.
  - Grants alternate 0,2,0,2.
  - CPU 1's `rspData` stays 0.
- Grant CPU 1 at `reqAddr`=32'h30, then idle 5 cycles.
  - `rspData[1]`=32'hA5A5_0030 held throughout.
  - `rspValid`=0 after the first cycle.
- Assert `rst` for 1 cycle mid-stream with `lastGnt`=1.
  - All `rspValid` and `rspData` read 0 next cycle.
  - `lastGnt`=2.
  - First post-reset grant is CPU 0.
- Random `req`/`reqAddr` for 2000 cycles, with scoreboard checks:
  - `gnt` is one-hot or zero.
  - No requester waits more than nCPUs-1 cycles.
  - Each `rspData` equals the model of its granted address.
